icu_sequencer: RTL and testbench
================================

Name: icu_sequencer

Overview:
- Program-side counterpart of the 1-bit ICU: owns the program counter and program-memory address, and presents the opcode to the ICU.
- Consumes the ICU's control outputs (jmp, rtn, flag_f) to perform jumps, subroutine call/return through a hardware return stack, and halt on NOPF.
- Sits between the program ROM (combinational read) and the ICU `instruction` input.
- Drives the ICU reset.

Parameters:
- ADDR_W, 8, program counter / ROM address width.
- STACK_DEPTH, 4, return-stack entries (≥1).
- RESET_PC, 0, PC value after reset.
- HALT_ON_NOPF, 1, 1: a flag_f pulse halts the sequencer; 0: flag_f ignored.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  leave IDLE/HALT and run.
- prog_addr  out  ADDR_W  ROM address, equals PC.
- prog_data  in  ADDR_W+5  ROM word: [3:0] opcode, [ADDR_W+3:4] target, [ADDR_W+4] call bit.
- instruction  out  4  opcode to ICU (instruction_t encoding; NOPO=0, JMP=C, RTN=D, NOPF=F).
- jmp_i  in  1  ICU jmp output.
- rtn_i  in  1  ICU rtn output.
- flag_f_i  in  1  ICU flag_f output.
- icu_rst  out  1  active-high ICU reset.
- running  out  1  state==RUN.
- halted  out  1  state==HALT.
- sp  out  $clog2(STACK_DEPTH+1)  stack occupancy.
- stack_ovf  out  1  sticky overflow error.
- stack_unf  out  1  sticky underflow error.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE, PC=RESET_PC, sp=0, stack_ovf=stack_unf=0.
  - Outputs after reset: icu_rst=1, instruction=NOPO, running=0, halted=0.
- States: IDLE, RUN, HALT.
  - icu_rst=1 only in IDLE.
  - instruction = prog_data[3:0] in RUN, else NOPO (combinational).
- IDLE → RUN on start=1; clears stack_ovf/stack_unf; PC unchanged. jmp_i/rtn_i/flag_f_i ignored.
- HALT → RUN on start=1; clears errors; PC, stack and sp retained.
- RUN, per posedge, priority order (first match wins):
  1. rtn_i=1:
     - sp>0: PC <= stack[sp-1], sp--.
     - sp=0: stack_unf <= 1, PC <= PC+1.
  2. jmp_i=1: PC <= prog_data[ADDR_W+3:4].
     - If call bit set and sp<STACK_DEPTH: push PC+1, sp++.
     - If call bit set and sp=STACK_DEPTH: stack_ovf <= 1, no push, jump still taken.
  3. flag_f_i=1 and HALT_ON_NOPF=1: PC <= PC+1, state <= HALT.
  4. Otherwise: PC <= PC+1.
- start while in RUN is ignored.
- Timing relative to the ICU:
  - The ICU latches the opcode on negedge and raises jmp/rtn/flag_f for the second half of that cycle.
  - The sequencer samples them at the next posedge while the same word is still on prog_data, so the jump target is taken directly from prog_data; no operand latch.
  - Redirect latency: one cycle. The word fetched after a JMP word's cycle is the target word.
- RTN skip: the ICU skips the instruction following RTN, so the word fetched at the return address is skipped by the ICU. Programs place a NOPO after each call site. The pushed address is call address+1.
- Wrap-around: PC+1 is modulo 2^ADDR_W (max → 0). A pushed return address wraps the same way.
- Reset in RUN or HALT aborts immediately to the reset state; the stack is discarded.
- No X on any output after the first reset cycle.

Test Plan:
- Reset/start: rst=0 for 2 cycles, then rst=1, start=0 for 3 cycles → prog_addr=0, instruction=0, icu_rst=1. Pulse start → next cycles prog_addr 0,1,2,…; icu_rst=0, running=1.
- Jump:
  - ROM[3]={call=0, tgt=0x40, op=C}; assert jmp_i during the cycle prog_addr=3 → next prog_addr=0x40, sp=0.
  - At PC=0xFF with no jump → next PC=0x00.
- Call/return:
  - ROM[5]={call=1, tgt=0x80, op=C}, jmp_i at PC=5 → PC=0x80, sp=1.
  - Later rtn_i at PC=0x83 → PC=6, sp=0.
- Overflow: STACK_DEPTH=4, five nested calls → sp saturates at 4, stack_ovf=1 on the 5th call, PC=5th target. Five returns → fifth return sets stack_unf=1 and PC increments.
- Halt/resume:
  - flag_f_i at PC=0x10 → halted=1, instruction=NOPO, prog_addr=0x11 held for 5 cycles.
  - start → running, PC 0x11,0x12…; errors cleared.
- Priority/reset: rtn_i and jmp_i together with sp=1 → pop wins, jump ignored. rst=0 mid-RUN with sp=3 → IDLE, PC=RESET_PC, sp=0.

Source files
------------

// File: rtl/icu_sequencer.sv
// Program-side sequencer for the 1-bit ICU: owns the PC, fetches ROM words, and
// applies jump / call / return / halt decisions reported back by the ICU.
// Handshake: there is no valid/ready pair; the ICU asserts jmp_i/rtn_i/flag_f_i
// in the second half of the cycle holding a word, and they are consumed on the
// next posedge while that same word is still on prog_data.
module icu_sequencer #(
  parameter int                ADDR_W       = 8,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC     = '0,
  parameter bit                HALT_ON_NOPF = 1'b1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  output logic [ADDR_W-1:0]                  prog_addr,
  input  logic [ADDR_W+4:0]                  prog_data,
  output logic [3:0]                         instruction,
  input  logic                               jmp_i,
  input  logic                               rtn_i,
  input  logic                               flag_f_i,
  output logic                               icu_rst,
  output logic                               running,
  output logic                               halted,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_ovf,
  output logic                               stack_unf
);

  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              push_en;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];

  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] tgt;
  logic              call_bit;
  logic [IDX_W-1:0]  top_idx;
  logic [IDX_W-1:0]  push_idx;

  assign pc_inc   = pc_q + ADDR_W'(1);
  assign tgt      = prog_data[ADDR_W+3:4];
  assign call_bit = prog_data[ADDR_W+4];
  assign top_idx  = IDX_W'(sp_q - SP_W'(1));
  assign push_idx = IDX_W'(sp_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entries above sp are dead, so the stack array needs no reset.
  always_ff @(posedge clk) begin
    if (push_en) stack_q[push_idx] <= pc_inc;
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push_en = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_RUN;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
        end
      end
      ST_RUN: begin
        if (rtn_i) begin
          if (sp_q != '0) begin
            pc_d = stack_q[top_idx];
            sp_d = sp_q - SP_W'(1);
          end else begin
            unf_d = 1'b1;
            pc_d  = pc_inc;
          end
        end else if (jmp_i) begin
          pc_d = tgt;
          // A call into a full stack still jumps; only the push is dropped.
          if (call_bit) begin
            if (sp_q != SP_FULL) begin
              push_en = 1'b1;
              sp_d    = sp_q + SP_W'(1);
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else if (flag_f_i && HALT_ON_NOPF) begin
          pc_d    = pc_inc;
          state_d = ST_HALT;
        end else begin
          pc_d = pc_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign prog_addr   = pc_q;
  assign instruction = (state_q == ST_RUN) ? prog_data[3:0] : 4'h0;
  assign icu_rst     = (state_q == ST_IDLE);
  assign running     = (state_q == ST_RUN);
  assign halted      = (state_q == ST_HALT);
  assign sp          = sp_q;
  assign stack_ovf   = ovf_q;
  assign stack_unf   = unf_q;

endmodule

// File: tb/tb_icu_sequencer.sv
// Bench for icu_sequencer: directed scenarios then random control traffic, all
// compared every cycle against a queue-based program-flow model.
module tb_icu_sequencer;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 4;

  // clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              jmp_i = 1'b0;
  logic              rtn_i = 1'b0;
  logic              flag_f_i = 1'b0;
  logic [ADDR_W-1:0] prog_addr;
  logic [ADDR_W+4:0] prog_data;
  logic [3:0]        instruction;
  logic              icu_rst, running, halted, stack_ovf, stack_unf;
  logic [2:0]        sp;

  logic [ADDR_W+4:0] rom [256];
  assign prog_data = rom[prog_addr];

  icu_sequencer #(.ADDR_W(ADDR_W), .STACK_DEPTH(DEPTH), .RESET_PC(8'h00), .HALT_ON_NOPF(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_addr(prog_addr), .prog_data(prog_data),
    .instruction(instruction), .jmp_i(jmp_i), .rtn_i(rtn_i), .flag_f_i(flag_f_i),
    .icu_rst(icu_rst), .running(running), .halted(halted), .sp(sp),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  int checks = 0;
  int failures = 0;

  // reference model: mode 0=idle 1=run 2=halt, return addresses in a queue
  int m_mode;
  int m_pc;
  int m_ovf, m_unf;
  int ret_q[$];

  function automatic logic [12:0] mk(input int call, input int target, input int op);
    return 13'(call * 4096 + target * 16 + op);
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_pc = 0; m_ovf = 0; m_unf = 0;
    ret_q.delete();
  endfunction

  function automatic void model_step(input int st, input int j, input int r, input int f);
    int w, target, call;
    w      = int'(rom[m_pc]);
    target = (w / 16) % 256;
    call   = (w / 4096) % 2;
    if (m_mode != 1) begin
      if (st != 0) begin
        m_mode = 1; m_ovf = 0; m_unf = 0;
      end
    end else if (r != 0) begin
      if (ret_q.size() > 0) m_pc = ret_q.pop_back();
      else begin
        m_unf = 1; m_pc = (m_pc + 1) % 256;
      end
    end else if (j != 0) begin
      if (call != 0) begin
        if (ret_q.size() < DEPTH) ret_q.push_back((m_pc + 1) % 256);
        else m_ovf = 1;
      end
      m_pc = target;
    end else if (f != 0) begin
      m_pc = (m_pc + 1) % 256; m_mode = 2;
    end else begin
      m_pc = (m_pc + 1) % 256;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_instr;
    exp_instr = (m_mode == 1) ? int'(rom[m_pc]) % 16 : 0;
    chk("prog_addr", 32'(prog_addr), 32'(m_pc));
    chk("sp", 32'(sp), 32'(ret_q.size()));
    chk("running", 32'(running), 32'(m_mode == 1));
    chk("halted", 32'(halted), 32'(m_mode == 2));
    chk("icu_rst", 32'(icu_rst), 32'(m_mode == 0));
    chk("instruction", 32'(instruction), 32'(exp_instr));
    chk("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("stack_unf", 32'(stack_unf), 32'(m_unf));
  endtask

  // driver: apply inputs, clock once, advance model, compare
  task automatic step(input logic r_n, input logic st, input logic j, input logic r, input logic f);
    rst = r_n; start = st; jmp_i = j; rtn_i = r; flag_f_i = f;
    @(posedge clk);
    #1;
    if (!r_n) model_reset();
    else model_step(int'(st), int'(j), int'(r), int'(f));
    check_all();
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 13'($urandom_range(0, 8191));
    rom[8'h03] = mk(0, 8'h40, 4'hC);
    rom[8'h40] = mk(0, 8'hFF, 4'hC);
    rom[8'h05] = mk(1, 8'h80, 4'hC);
    rom[8'h06] = mk(1, 8'h90, 4'hC);
    rom[8'h90] = mk(1, 8'hA0, 4'hC);
    rom[8'hA0] = mk(1, 8'hB0, 4'hC);
    rom[8'hB0] = mk(1, 8'hC0, 4'hC);
    rom[8'hC0] = mk(1, 8'hD0, 4'hC);
    rom[8'h08] = mk(0, 8'h10, 4'hC);
    rom[8'h10] = mk(0, 8'h00, 4'hF);
    rom[8'h12] = mk(1, 8'h30, 4'hC);
    rom[8'h30] = mk(0, 8'h77, 4'hD);
    rom[8'h13] = mk(1, 8'h50, 4'hC);
    rom[8'h50] = mk(1, 8'h60, 4'hC);
    rom[8'h60] = mk(1, 8'h70, 4'hC);

    // reset then idle with start low
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_steps(3);
    chk("idle_addr", 32'(prog_addr), 32'h0);
    chk("idle_icu_rst", 32'(icu_rst), 32'h1);

    // start and sequential fetch, plain jump at 3
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_running", 32'(running), 32'h1);
    idle_steps(3);
    chk("seq_addr", 32'(prog_addr), 32'h3);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("jmp_addr", 32'(prog_addr), 32'h40);

    // jump to 0xFF then wrap to 0
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle_steps(1);
    chk("wrap_addr", 32'(prog_addr), 32'h0);

    // call at 5 and return at 0x83
    idle_steps(5);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("call_addr", 32'(prog_addr), 32'h80);
    chk("call_sp", 32'(sp), 32'h1);
    idle_steps(3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ret_addr", 32'(prog_addr), 32'h6);
    chk("ret_sp", 32'(sp), 32'h0);

    // five nested calls then five returns
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf_addr", 32'(prog_addr), 32'hD0);
    chk("ovf_sp", 32'(sp), 32'h4);
    chk("ovf_flag", 32'(stack_ovf), 32'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("unf_flag", 32'(stack_unf), 32'h1);
    chk("unf_addr", 32'(prog_addr), 32'h8);

    // halt at 0x10, hold while ICU outputs toggle, then resume
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    chk("halt_addr", 32'(prog_addr), 32'h11);
    chk("halt_flag", 32'(halted), 32'h1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("resume_ovf", 32'(stack_ovf), 32'h0);
    idle_steps(1);
    chk("resume_addr", 32'(prog_addr), 32'h12);

    // rtn beats jmp, then reset with a deep stack
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("prio_addr", 32'(prog_addr), 32'h13);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("deep_sp", 32'(sp), 32'h3);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("abort_sp", 32'(sp), 32'h0);
    chk("abort_addr", 32'(prog_addr), 32'h0);

    // random control traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 99) != 0),
           1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 29) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
